// File: rtl/cfg_loader.sv
// cfg_loader: power-up configuration image loader.
// Reads NUM_PAGES 8-byte EEPROM pages with per-page timeout and retry.
module cfg_loader #(
  parameter int          NUM_PAGES    = 2,
  parameter logic [7:0]  BASE_ADDR    = 8'h00,
  parameter logic [31:0] WAIT_CNT_MAX = 32'd10000000,
  parameter logic [31:0] TIMEOUT_CNT  = 32'd400000,
  parameter int          MAX_RETRIES  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_reload,
  output logic                    o_eep_start,
  output logic [7:0]              o_eep_page_addr,
  input  logic                    i_eep_busy,
  input  logic                    i_eep_done,
  input  logic [63:0]             i_eep_page_data,
  output logic [64*NUM_PAGES-1:0] o_cfg_data,
  output logic [7:0]              o_node_id,
  output logic                    o_cfg_valid,
  output logic                    o_cfg_error,
  output logic                    o_loading
);

  localparam int         DW        = 64 * NUM_PAGES;
  localparam logic [3:0] LAST_IDX  = 4'(NUM_PAGES - 1);
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_ISSUE,
    S_WAIT_DONE,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] wait_cnt;
  logic [31:0] wait_cnt_n;
  logic [31:0] tmo_cnt;
  logic [31:0] tmo_cnt_n;
  logic [3:0]  idx;
  logic [3:0]  idx_n;
  logic [7:0]  retries;
  logic [7:0]  retries_n;
  logic        start_n;
  logic [7:0]  addr_n;
  logic [DW-1:0] data_n;
  logic [7:0]  node_n;
  logic        valid_n;
  logic        error_n;
  logic        loading_n;

  // Next-state, counters and next value of every registered output.
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    tmo_cnt_n  = tmo_cnt;
    idx_n      = idx;
    retries_n  = retries;
    start_n    = 1'b0;
    addr_n     = o_eep_page_addr;
    data_n     = o_cfg_data;
    node_n     = o_node_id;

    case (state)
      S_INIT_WAIT: begin
        idx_n     = '0;
        retries_n = '0;
        if (wait_cnt == WAIT_CNT_MAX) begin
          state_n = S_ISSUE;
        end else begin
          wait_cnt_n = wait_cnt + 32'd1;
        end
      end

      S_ISSUE: begin
        if (!i_eep_busy) begin
          start_n   = 1'b1;
          addr_n    = BASE_ADDR + {1'b0, idx, 3'b000};
          tmo_cnt_n = '0;
          state_n   = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        tmo_cnt_n = tmo_cnt + 32'd1;
        // A completion in the expiry cycle still counts as success.
        if (i_eep_done) begin
          for (int k = 0; k < NUM_PAGES; k++) begin
            if (idx == 4'(k)) begin
              data_n[64*k +: 64] = i_eep_page_data;
            end
          end
          state_n = S_NEXT;
        end else if (tmo_cnt_n == TIMEOUT_CNT) begin
          retries_n = retries + 8'd1;
          if (retries_n == RETRY_MAX) begin
            state_n = S_FAIL;
          end else begin
            state_n = S_ISSUE;
          end
        end
      end

      S_NEXT: begin
        if (idx == LAST_IDX) begin
          node_n  = o_cfg_data[7:0];
          state_n = S_DONE;
        end else begin
          idx_n     = idx + 4'd1;
          retries_n = '0;
          state_n   = S_ISSUE;
        end
      end

      S_DONE, S_FAIL: begin
        if (i_reload) begin
          idx_n     = '0;
          retries_n = '0;
          state_n   = S_ISSUE;
        end
      end

      default: begin
        state_n = S_INIT_WAIT;
      end
    endcase

    valid_n   = (state_n == S_DONE);
    error_n   = (state_n == S_FAIL);
    loading_n = (state_n == S_ISSUE) ||
                (state_n == S_WAIT_DONE) ||
                (state_n == S_NEXT);
  end

  // State, counters and outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_INIT_WAIT;
      wait_cnt        <= '0;
      tmo_cnt         <= '0;
      idx             <= '0;
      retries         <= '0;
      o_eep_start     <= 1'b0;
      o_eep_page_addr <= '0;
      o_cfg_data      <= '0;
      o_node_id       <= '0;
      o_cfg_valid     <= 1'b0;
      o_cfg_error     <= 1'b0;
      o_loading       <= 1'b0;
    end else begin
      state           <= state_n;
      wait_cnt        <= wait_cnt_n;
      tmo_cnt         <= tmo_cnt_n;
      idx             <= idx_n;
      retries         <= retries_n;
      o_eep_start     <= start_n;
      o_eep_page_addr <= addr_n;
      o_cfg_data      <= data_n;
      o_node_id       <= node_n;
      o_cfg_valid     <= valid_n;
      o_cfg_error     <= error_n;
      o_loading       <= loading_n;
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: deadline-based reference model plus directed and
// randomized EEPROM responder scenarios for cfg_loader.
module tb_cfg_loader;

  localparam int         NP    = 2;
  localparam logic [7:0] BASE  = 8'h10;
  localparam int         WAITC = 10;
  localparam int         TOUT  = 20;
  localparam int         MAXR  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_reload = 1'b0;
  logic          i_eep_busy = 1'b0;
  logic          i_eep_done = 1'b0;
  logic [63:0]   i_eep_page_data = '0;
  logic          o_eep_start;
  logic [7:0]    o_eep_page_addr;
  logic [64*NP-1:0] o_cfg_data;
  logic [7:0]    o_node_id;
  logic          o_cfg_valid;
  logic          o_cfg_error;
  logic          o_loading;

  cfg_loader #(
    .NUM_PAGES   (NP),
    .BASE_ADDR   (BASE),
    .WAIT_CNT_MAX(32'd10),
    .TIMEOUT_CNT (32'd20),
    .MAX_RETRIES (MAXR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_reload       (i_reload),
    .o_eep_start    (o_eep_start),
    .o_eep_page_addr(o_eep_page_addr),
    .i_eep_busy     (i_eep_busy),
    .i_eep_done     (i_eep_done),
    .i_eep_page_data(i_eep_page_data),
    .o_cfg_data     (o_cfg_data),
    .o_node_id      (o_node_id),
    .o_cfg_valid    (o_cfg_valid),
    .o_cfg_error    (o_cfg_error),
    .o_loading      (o_loading)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: what the loader is doing, tracked by absolute
  // deadlines (cycle numbers) rather than counters.
  typedef enum int {M_WAIT, M_ISSUE, M_READ, M_NEXT, M_DONE, M_FAIL} mmode_t;
  mmode_t      m_mode = M_WAIT;
  bit          armed = 1'b0;
  int          m_issue_at, m_deadline, m_page, m_tries;
  logic        m_start = 1'b0;
  logic [7:0]  m_addr = '0;
  logic [7:0]  m_node = '0;
  logic [63:0] img [NP];

  always @(posedge clk) begin
    cyc = cyc + 1;
    m_start = 1'b0;
    if (reset) begin
      armed      = 1'b1;
      m_mode     = M_WAIT;
      m_issue_at = cyc + WAITC + 1;
      m_page     = 0;
      m_tries    = 0;
      m_addr     = '0;
      m_node     = '0;
      for (int k = 0; k < NP; k++) img[k] = '0;
    end else if (armed) begin
      case (m_mode)
        M_WAIT: if (cyc == m_issue_at) m_mode = M_ISSUE;
        M_ISSUE: if (!i_eep_busy) begin
          m_start    = 1'b1;
          m_addr     = 8'((int'(BASE) + 8 * m_page) % 256);
          m_deadline = cyc + TOUT;
          m_mode     = M_READ;
        end
        M_READ: if (i_eep_done) begin
          img[m_page] = i_eep_page_data;
          m_mode = M_NEXT;
        end else if (cyc == m_deadline) begin
          m_tries++;
          m_mode = (m_tries == MAXR) ? M_FAIL : M_ISSUE;
        end
        M_NEXT: if (m_page == NP - 1) begin
          m_node = img[0][7:0];
          m_mode = M_DONE;
        end else begin
          m_page++;
          m_tries = 0;
          m_mode  = M_ISSUE;
        end
        default: if (i_reload) begin
          m_page  = 0;
          m_tries = 0;
          m_mode  = M_ISSUE;
        end
      endcase
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      check("start", o_eep_start, m_start);
      check("page_addr", o_eep_page_addr, m_addr);
      check("cfg_data", o_cfg_data, {img[1], img[0]});
      check("node_id", o_node_id, m_node);
      check("cfg_valid", o_cfg_valid, m_mode == M_DONE);
      check("cfg_error", o_cfg_error, m_mode == M_FAIL);
      check("loading", o_loading,
            m_mode inside {M_ISSUE, M_READ, M_NEXT});
      check("valid_error_excl", o_cfg_valid & o_cfg_error, 1'b0);
    end
  end

  // EEPROM responder: each start consumes a latency from plan
  // (0 = never answers); done is sampled 'latency' edges after start.
  int          cd = 0;
  int          pg = 0;
  int          lat;
  int          plan [$];
  int          st_cyc [$];
  logic [7:0]  st_addr [$];
  logic [7:0]  diff;
  logic [63:0] mem [NP];
  bit          rand_en = 1'b0;
  bit          busy_force = 1'b0;
  bit          reload_req = 1'b0;

  always @(negedge clk) begin
    if (o_eep_start) begin
      st_cyc.push_back(cyc);
      st_addr.push_back(o_eep_page_addr);
      if (plan.size() > 0) lat = plan.pop_front();
      else if (rand_en) lat = $urandom_range(24, 1);
      else lat = 5;
      cd   = lat;
      diff = o_eep_page_addr - BASE;
      pg   = int'(diff >> 3) % NP;
    end
    i_eep_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        i_eep_done      = 1'b1;
        i_eep_page_data = mem[pg];
      end
    end
    if (rand_en) begin
      if ($urandom_range(40) == 0) begin
        i_eep_done      = 1'b1;
        i_eep_page_data = {$urandom, $urandom};
      end
      i_eep_busy = ($urandom_range(3) == 0);
      i_reload   = ($urandom_range(30) == 0);
    end else begin
      i_eep_busy = busy_force;
      i_reload   = reload_req;
      reload_req = 1'b0;
    end
  end

  int rel;
  int r;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rel = cyc + 1;
    plan.delete();
    st_cyc.delete();
    st_addr.delete();
    cd = 0;
  endtask

  task automatic wait_end(input string name, input int n);
    for (int i = 0; i < n && !(o_cfg_valid || o_cfg_error); i++) tick();
    check(name, o_cfg_valid | o_cfg_error, 1'b1);
  endtask

  initial begin
    mem[0] = 64'h0123_4567_89AB_CDA5;
    mem[1] = 64'h1122_3344_5566_7788;

    // Reset state
    do_reset();
    check("rst_valid", o_cfg_valid, 1'b0);
    check("rst_loading", o_loading, 1'b0);
    check("rst_addr", o_eep_page_addr, 8'h00);

    // Nominal load
    plan = '{5, 5};
    wait_end("nom_end", 300);
    check("nom_starts", st_cyc.size(), 2);
    if (st_cyc.size() >= 2) begin
      check("nom_first_delay", st_cyc[0] - rel, 11);
      check("nom_gap", st_cyc[1] - st_cyc[0], 7);
      check("nom_addr0", st_addr[0], 8'h10);
      check("nom_addr1", st_addr[1], 8'h18);
    end
    check("nom_node", o_node_id, 8'hA5);
    check("nom_page1", o_cfg_data[127:64], 64'h1122334455667788);
    check("nom_page0", o_cfg_data[63:0], 64'h0123456789ABCDA5);
    check("nom_valid", o_cfg_valid, 1'b1);
    check("nom_error", o_cfg_error, 1'b0);

    // Busy hold: busy seen high on the 7 edges after ISSUE entry
    busy_force = 1'b1;
    do_reset();
    plan = '{5, 5};
    for (int i = 0; i < 100 && cyc < rel + 17; i++) tick();
    busy_force = 1'b0;
    wait_end("busy_end", 300);
    check("busy_starts", st_cyc.size(), 2);
    if (st_cyc.size() >= 1) check("busy_start_cyc", st_cyc[0] - rel, 18);

    // Single timeout on page 1
    do_reset();
    plan = '{5, 0, 5};
    wait_end("tmo_end", 300);
    check("tmo_starts", st_cyc.size(), 3);
    if (st_cyc.size() >= 3) begin
      check("tmo_gap", st_cyc[2] - st_cyc[1], 21);
      check("tmo_addr", st_addr[2], 8'h18);
    end
    check("tmo_valid", o_cfg_valid, 1'b1);
    check("tmo_error", o_cfg_error, 1'b0);

    // Exhausted retries on page 0, then reload
    do_reset();
    plan = '{0, 0};
    wait_end("fail_end", 300);
    check("fail_starts", st_cyc.size(), 2);
    if (st_cyc.size() >= 2) check("fail_gap", st_cyc[1] - st_cyc[0], 21);
    check("fail_error", o_cfg_error, 1'b1);
    check("fail_loading", o_loading, 1'b0);
    check("fail_valid", o_cfg_valid, 1'b0);
    plan = '{5, 5};
    reload_req = 1'b1;
    r = cyc + 1;
    tick();
    tick();
    tick();
    check("reload_err_clr", o_cfg_error, 1'b0);
    check("reload_starts", st_cyc.size(), 3);
    if (st_cyc.size() >= 3) begin
      check("reload_start_cyc", st_cyc[2] - r, 1);
      check("reload_addr", st_addr[2], 8'h10);
    end
    wait_end("reload_end", 300);
    check("reload_valid", o_cfg_valid, 1'b1);

    // Reset while page 1 is outstanding
    do_reset();
    plan = '{5, 0};
    for (int i = 0; i < 200 && st_cyc.size() < 2; i++) tick();
    tick();
    tick();
    check("mid_loading", o_loading, 1'b1);
    reset = 1'b1;
    tick();
    check("mid_rst_data", o_cfg_data, '0);
    check("mid_rst_loading", o_loading, 1'b0);
    check("mid_rst_addr", o_eep_page_addr, 8'h00);
    do_reset();
    plan = '{5, 5};
    wait_end("mid_end", 300);
    if (st_cyc.size() >= 1) check("mid_first_delay", st_cyc[0] - rel, 11);
    check("mid_valid", o_cfg_valid, 1'b1);

    // Done arrives on the exact timeout cycle of page 1
    do_reset();
    plan = '{5, 20};
    wait_end("dt_end", 300);
    tick();
    tick();
    check("dt_starts", st_cyc.size(), 2);
    check("dt_valid", o_cfg_valid, 1'b1);
    check("dt_page1", o_cfg_data[127:64], 64'h1122334455667788);

    // Randomized traffic: busy, reloads, stray done pulses, resets
    mem[0] = {$urandom, $urandom};
    mem[1] = {$urandom, $urandom};
    rand_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(499) == 0) do_reset();
    end
    rand_en = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
